// File: rtl/hit_pkg.sv
// Constants shared by the hit input conditioner and the score counter.
// Also holds the priority helper that picks the reported hit channel.
package hit_pkg;

  localparam int NUM_HIT_CH              = 3;
  localparam int HIT_ID_W                = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int DEFAULT_LOCKOUT_CYCLES  = 2000000;
  localparam int DEFAULT_CNT_W           = 32;

  // Index of the lowest-numbered set bit; 0 when no bit is set.
  function automatic logic [HIT_ID_W-1:0] lowest_hit(input logic [NUM_HIT_CH-1:0] pulses);
    logic [HIT_ID_W-1:0] id;
    id = '0;
    for (int i = NUM_HIT_CH - 1; i >= 0; i--) begin
      if (pulses[i]) id = HIT_ID_W'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One sensor channel: two-flop synchroniser, stable-count debouncer and a
// delayed copy of the debounced level for rising-edge detection.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             s;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
      level     <= 1'b0;
      level_d   <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      s         <= sync_meta;
      level_d   <= level;
      // The count only survives while the synchronised sample keeps
      // disagreeing with the accepted level; the >= guard keeps it from wrapping.
      if (s == level) begin
        cnt <= '0;
      end else if (cnt >= DB_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/hit_input_conditioner.sv
// Conditions three raw hit sensors into clean single-cycle hit strobes,
// with a global lockout so one physical strike is never scored twice.
module hit_input_conditioner
  import hit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enA,
  input  logic                  in0,
  input  logic                  in1,
  input  logic                  in2,
  output logic [NUM_HIT_CH-1:0] hit_level,
  output logic [NUM_HIT_CH-1:0] hit_pulse,
  output logic                  hit_any,
  output logic [HIT_ID_W-1:0]   hit_id,
  output logic                  lockout
);

  localparam longint CNT_MAX = (CNT_W >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF
                                             : longint'((64'd1 << CNT_W) - 64'd1);

  generate
    if (CNT_W < 1 || DEBOUNCE_CYCLES < 1 || LOCKOUT_CYCLES < 0 ||
        longint'(DEBOUNCE_CYCLES) > CNT_MAX || longint'(LOCKOUT_CYCLES) > CNT_MAX) begin : g_bad_params
      $error("hit_input_conditioner: DEBOUNCE_CYCLES/LOCKOUT_CYCLES out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES);
  localparam logic             LOCK_EN   = (LOCKOUT_CYCLES != 0);

  logic [NUM_HIT_CH-1:0] raw;
  logic [NUM_HIT_CH-1:0] level;
  logic [NUM_HIT_CH-1:0] rise;

  assign raw = {in2, in1, in0};

  for (genvar i = 0; i < NUM_HIT_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clock(clock),
      .reset(reset),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign hit_level = level;

  logic [CNT_W-1:0]      lock_cnt;
  logic [CNT_W-1:0]      lock_cnt_next;
  logic                  lockout_active;
  logic [NUM_HIT_CH-1:0] pulse_next;

  // The window covers pulse cycles P+1..P+LOCKOUT_CYCLES: a rise seen in the
  // strobe cycle itself is blocked, and the final count value (1) no longer
  // blocks, because the pulse it would make lands just outside the window.
  always_comb begin
    lockout_active = (LOCK_EN && hit_any) || (lock_cnt > CNT_W'(1));
    pulse_next     = rise & {NUM_HIT_CH{enA}} & ~{NUM_HIT_CH{lockout_active}};
    lock_cnt_next  = lock_cnt;
    if (LOCK_EN && hit_any) begin
      lock_cnt_next = LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt_next = lock_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_pulse <= '0;
      hit_any   <= 1'b0;
      hit_id    <= '0;
      lock_cnt  <= '0;
      lockout   <= 1'b0;
    end else begin
      hit_pulse <= pulse_next;
      hit_any   <= |pulse_next;
      hit_id    <= lowest_hit(pulse_next);
      lock_cnt  <= lock_cnt_next;
      lockout   <= (lock_cnt_next != '0);
    end
  end

endmodule

// File: tb/tb_hit_input_conditioner.sv
// Directed bench for hit_input_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10;
// expected strobes are queued at stimulus time and matched by a negedge monitor.
module tb_hit_input_conditioner;

  localparam int DB = 4;
  localparam int LK = 10;
  localparam int W  = 38;  // {cycle[31:0], pulse[2:0], any, id[1:0]}

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enA   = 1'b0;
  logic       in0   = 1'b0;
  logic       in1   = 1'b0;
  logic       in2   = 1'b0;
  logic [2:0] hit_level;
  logic [2:0] hit_pulse;
  logic       hit_any;
  logic [1:0] hit_id;
  logic       lockout;

  int unsigned cyc = 0;
  int unsigned c;
  int          total = 0;
  int          bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;

  hit_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .LOCKOUT_CYCLES (LK),
    .CNT_W          (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enA      (enA),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .hit_level(hit_level),
    .hit_pulse(hit_pulse),
    .hit_any  (hit_any),
    .hit_id   (hit_id),
    .lockout  (lockout)
  );

  // Clock and cycle counter: cycle n is the interval after rising edge n.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_hit(input int unsigned at, input logic [2:0] p, input logic [1:0] id);
    exp_q.push_back({at, p, 1'b1, id});
  endtask

  // Scoreboard monitor: every strobe the DUT shows must match the head of the queue.
  always @(negedge clock) begin
    if (hit_any || hit_pulse != 3'b000) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_hit: got pulse=%b any=%b id=%0d at cycle %0d, want no strobe",
                 hit_pulse, hit_any, hit_id, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_act = {cyc, hit_pulse, hit_any, hit_id};
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL scoreboard_hit: got cycle=%0d pulse=%b any=%b id=%0d, want cycle=%0d pulse=%b any=%b id=%0d",
                   mon_act[37:6], mon_act[5:3], mon_act[2], mon_act[1:0],
                   mon_exp[37:6], mon_exp[5:3], mon_exp[2], mon_exp[1:0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    check("reset_level", hit_level, 0);
    check("reset_pulse", hit_pulse, 0);
    check("reset_any", hit_any, 0);
    check("reset_id", hit_id, 0);
    check("reset_lockout", lockout, 0);
    reset = 1'b1;
    enA   = 1'b1;
    tick(4);

    // 1. Clean press on in1: strobe in cycle 7, lockout cycles 8..17
    c = cyc; in1 = 1'b1; expect_hit(c + 7, 3'b010, 2'd1);
    tick(7);  check("s1_lockout_at_pulse", lockout, 0);
    tick(1);  check("s1_lockout_first", lockout, 1);
    tick(9);  check("s1_lockout_last", lockout, 1);
    tick(1);  check("s1_lockout_end", lockout, 0);
    check("s1_level_high", hit_level, 3'b010);
    in1 = 1'b0;
    tick(10); check("s1_level_low", hit_level, 3'b000);

    // 2. Three-cycle glitch is rejected; four-cycle high is accepted
    c = cyc; in0 = 1'b1;
    tick(3); in0 = 1'b0;
    tick(4); check("s2_glitch_level", hit_level, 3'b000);
    tick(5);
    c = cyc; in0 = 1'b1; expect_hit(c + 7, 3'b001, 2'd0);
    tick(4); in0 = 1'b0;
    tick(3); check("s2_level_set", hit_level, 3'b001);
    tick(25);

    // 3a. Rise qualifying at P+5 dropped, at P+11 accepted
    c = cyc; in0 = 1'b1; expect_hit(c + 7, 3'b001, 2'd0);
    tick(5); in2 = 1'b1;
    tick(6); in1 = 1'b1; expect_hit(c + 18, 3'b010, 2'd1);
    tick(8); check("s3_levels", hit_level, 3'b111);
    in0 = 1'b0; in1 = 1'b0; in2 = 1'b0;
    tick(30);

    // 3b. Rise qualifying at P+10 is still inside the window
    c = cyc; in0 = 1'b1; expect_hit(c + 7, 3'b001, 2'd0);
    tick(10); in1 = 1'b1;
    tick(12); check("s3b_levels", hit_level, 3'b011);
    in0 = 1'b0; in1 = 1'b0;
    tick(30);

    // 4. Simultaneous rises: one strobe, lowest id, single lockout window
    c = cyc; in0 = 1'b1; in2 = 1'b1; expect_hit(c + 7, 3'b101, 2'd0);
    tick(8); check("s4_lockout_first", lockout, 1);
    tick(9); check("s4_lockout_last", lockout, 1);
    tick(1); check("s4_lockout_end", lockout, 0);
    in0 = 1'b0; in2 = 1'b0;
    tick(12);

    // 5. Enable low: level tracks, no strobe, no lockout; re-enable while held
    enA = 1'b0;
    in1 = 1'b1;
    tick(12); check("s5_lockout_gated", lockout, 0);
    check("s5_level_tracks", hit_level, 3'b010);
    enA = 1'b1;
    tick(10); check("s5_lockout_after_en", lockout, 0);
    in1 = 1'b0;
    tick(12);

    // 6. Reset during lockout with in1 held; fresh strobe after release
    c = cyc; in1 = 1'b1; expect_hit(c + 7, 3'b010, 2'd1);
    tick(9); check("s6_lockout_before_reset", lockout, 1);
    reset = 1'b0;
    #1;
    check("s6_rst_level", hit_level, 0);
    check("s6_rst_pulse", hit_pulse, 0);
    check("s6_rst_any", hit_any, 0);
    check("s6_rst_id", hit_id, 0);
    check("s6_rst_lockout", lockout, 0);
    tick(3);
    reset = 1'b1;
    c = cyc; expect_hit(c + 7, 3'b010, 2'd1);
    tick(7); check("s6_level_after_release", hit_level, 3'b010);
    tick(15);
    in1 = 1'b0;
    tick(10);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
